ringbuffer_ctl: RTL

//  Parametrised successor ring buffer between LPC/TPM frame capture and the UART drain path.
//  All 2**AW entries are usable; the block reports fill level and almost-full.

---
 rtl/ringbuffer_pkg.sv | 13 +
 rtl/ringbuffer_if.sv | 34 +++
 rtl/ringbuffer_ram.sv | 25 ++
 rtl/ringbuffer_ctl.sv | 95 +++++++++
 4 files changed

// File: rtl/ringbuffer_pkg.sv
// ringbuffer_pkg: shared constants and helpers for the ring buffer slice.
//   MODE_DROP / MODE_OVERWRITE select the full-buffer policy of ringbuffer_ctl.
//   depth(aw) returns the number of entries addressed by an aw-bit pointer.
package ringbuffer_pkg;

    localparam bit MODE_DROP      = 1'b0;
    localparam bit MODE_OVERWRITE = 1'b1;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ringbuffer_if.sv
// ringbuffer_if: producer/consumer bus of the ring buffer.
//   master: drives flush, write_clk_enable, write_data, read_clk_enable, clear_overflow;
//           observes read_data, read_valid, empty, full, almost_full, level,
//           overflow, drop_count.
//   slave : the buffer side (directions mirrored).
interface ringbuffer_if #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int CW = 16
);
    logic          flush;
    logic          write_clk_enable;
    logic [DW-1:0] write_data;
    logic          read_clk_enable;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   level;
    logic          overflow;
    logic          clear_overflow;
    logic [CW-1:0] drop_count;

    modport master (
        output flush, write_clk_enable, write_data, read_clk_enable, clear_overflow,
        input  read_data, read_valid, empty, full, almost_full, level, overflow, drop_count
    );

    modport slave (
        input  flush, write_clk_enable, write_data, read_clk_enable, clear_overflow,
        output read_data, read_valid, empty, full, almost_full, level, overflow, drop_count
    );
endinterface

// File: rtl/ringbuffer_ram.sv
// ringbuffer_ram: simple dual-port storage, single clock, registered read.
//   clk           clock
//   we/waddr/wdata  write port
//   re/raddr        read port; rdata updates on the edge where re is high
// A read and a write to the same address in one cycle return the old
// contents (read-first); the full-buffer push+pop case depends on this.
module ringbuffer_ram #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ringbuffer_ctl.sv
// ringbuffer_ctl: ring buffer between frame capture and the UART drain path.
//   clk, reset  single clock, synchronous active-high reset
//   bus         ringbuffer_if slave: push/pop/flush/clear_overflow in;
//               read_data/read_valid, fill flags, level, overflow, drop_count out
// All 2**AW slots are usable because fill state is tracked by an AW+1 bit
// level counter instead of comparing pointers. A pop sampled at edge N
// loads the RAM output at N and read_data at N+1 (read_valid follows).
module ringbuffer_ctl
    import ringbuffer_pkg::*;
#(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter bit OVERWRITE   = MODE_DROP,
    parameter int AFULL_LEVEL = depth(AW) - 4,
    parameter int CW          = 16
) (
    input logic       clk,
    input logic       reset,
    ringbuffer_if.slave bus
);
    localparam int DEPTH  = depth(AW);
    localparam int STAGES = 1;

    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [DW-1:0]     ram_q, read_data;
    logic [STAGES:0]   vld_pipe;   // [0]: RAM read launched, [STAGES]: read_valid
    logic              overflow;
    logic [CW-1:0]     drop_count;
    logic              pop, push, drop, ovw, we;

    assign bus.empty       = (level == '0);
    assign bus.full        = (level == (AW+1)'(DEPTH));
    assign bus.almost_full = (level >= (AW+1)'(AFULL_LEVEL));
    assign bus.level       = level;
    assign bus.read_data   = read_data;
    assign bus.read_valid  = vld_pipe[STAGES];
    assign bus.overflow    = overflow;
    assign bus.drop_count  = drop_count;

    // A pop frees a slot this cycle, so push into a full buffer still lands
    // when paired with a pop; only an unpaired push to full is a loss.
    always_comb begin
        pop  = bus.read_clk_enable && !bus.empty && !bus.flush;
        push = bus.write_clk_enable && !bus.flush && (!bus.full || pop);
        drop = bus.write_clk_enable && !bus.flush && bus.full && !pop;
        ovw  = drop && OVERWRITE;
        we   = push || ovw;
    end

    ringbuffer_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (bus.write_data),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            vld_pipe   <= '0;
            read_data  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (bus.flush) begin
                // In-flight pops are cancelled; read_data keeps its last value.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                vld_pipe <= '0;
            end else begin
                if (we) wr_ptr <= wr_ptr + 1'b1;
                // Overwrite retires the oldest record without changing level.
                if (pop || ovw) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level <= level + 1'b1;
                else if (pop && !push) level <= level - 1'b1;
                vld_pipe <= {vld_pipe[STAGES-1:0], pop};
                if (vld_pipe[STAGES-1]) read_data <= ram_q;
            end
            if (bus.clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule
